// File: rtl/serial_alu_pkg.sv
// serial_alu shared definitions: opcode and FSM state encodings.
// Optional flags feature is enabled with SERIAL_ALU_FLAGS_EN.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_NOT = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: sum/and/not/xor select, carry and parity chain.
// Purely combinational; the top registers carry and parity between bits.
module serial_alu_slice
  import serial_alu_pkg::*;
(
  input  op_e  op_i,
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  input  logic par_i,
  output logic y_o,
  output logic carry_o,
  output logic par_o
);

  always_comb begin
    y_o     = 1'b0;
    carry_o = 1'b0;
    par_o   = par_i;
    unique case (op_i)
      OP_ADD: begin
        y_o     = a_i ^ b_i ^ carry_i;
        carry_o = (a_i & b_i) | (a_i & carry_i) | (b_i & carry_i);
      end
      OP_AND: y_o = a_i & b_i;
      OP_NOT: y_o = ~a_i;
      OP_XOR: begin
        y_o   = a_i ^ b_i;
        par_o = par_i ^ (a_i ^ b_i);
      end
      default: y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU top: FSM, bit counter, operand/result shift registers.
// Define SERIAL_ALU_FLAGS_EN to add the zero and ovf result flags.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             busy,
`ifdef SERIAL_ALU_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_e              op_q;
  logic             carry_q;
  logic             par_q;
  logic [WIDTH-1:0] y_q;
  logic             z_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_y;
  logic             carry_d;
  logic             par_d;
  logic [WIDTH-1:0] y_d;

  serial_alu_slice u_slice (
    .op_i    (op_q),
    .a_i     (a_q[0]),
    .b_i     (b_q[0]),
    .carry_i (carry_q),
    .par_i   (par_q),
    .y_o     (bit_y),
    .carry_o (carry_d),
    .par_o   (par_d)
  );

  // Result enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign y_d = {bit_y, y_q[WIDTH-1:1]};

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_q;
  logic ovf_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      par_q   <= 1'b0;
      y_q     <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op_e'(op);
            carry_q <= (op_e'(op) == OP_ADD) ? cin : 1'b0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          y_q     <= y_d;
          carry_q <= carry_d;
          par_q   <= par_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            unique case (op_q)
              OP_ADD:  z_q <= carry_d;
              OP_XOR:  z_q <= par_d;
              default: z_q <= 1'b0;
            endcase
`ifdef SERIAL_ALU_FLAGS_EN
            // carry_q here is the carry into the MSB.
            zero_q <= (y_d == '0);
            ovf_q  <= (op_q == OP_ADD) & (carry_q ^ carry_d);
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y    = y_q;
  assign z    = z_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: vector table, corner sequences, random.
// Define SERIAL_ALU_FLAGS_EN to also check zero and ovf.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         z;
  logic         busy;
  logic         done;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int busy_gaps = 0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .y     (y),
    .z     (z),
    .busy  (busy),
`ifdef SERIAL_ALU_FLAGS_EN
    .zero  (zero),
    .ovf   (ovf),
`endif
    .done  (done)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] y;
    logic         z;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference from word-level arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic ci,
                       output logic [W-1:0] ey, output logic ez,
                       output logic eovf);
    logic [W:0] sum;
    sum  = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
    eovf = 1'b0;
    case (o)
      2'b00: begin
        ey   = sum[W-1:0];
        ez   = sum[W];
        eovf = (aa[W-1] == bb[W-1]) && (ey[W-1] != aa[W-1]);
      end
      2'b01: begin ey = aa & bb; ez = 1'b0; end
      2'b10: begin ey = ~aa;     ez = 1'b0; end
      default: begin ey = aa ^ bb; ez = ^(aa ^ bb); end
    endcase
  endtask

  // Start an op, then wait (bounded) for done; poke_at>0 injects a
  // start pulse with other operands on that RUN cycle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic ci,
                       input int poke_at, output int lat);
    @(negedge clk);
    op = o; a = aa; b = bb; cin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    lat = 1;
    while (!done && lat < W + 6) begin
      if (!busy) busy_gaps++;
      start = (poke_at > 0 && lat == poke_at);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  logic [W-1:0] ey;
  logic         ez;
  logic         eovf;
  int           lat;

  initial begin
    vt[0] = '{2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[1] = '{2'b01, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vt[2] = '{2'b10, 8'hA5, 8'h00, 1'b0, 8'h5A, 1'b0};
    vt[3] = '{2'b11, 8'h0F, 8'h01, 1'b0, 8'h0E, 1'b1};
    vt[4] = '{2'b00, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0};
    vt[5] = '{2'b01, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0};
    vt[6] = '{2'b11, 8'h81, 8'h7E, 1'b1, 8'hFF, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y", 32'(y), 0);
    check("rst_z", 32'(z), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
`ifdef SERIAL_ALU_FLAGS_EN
    check("rst_zero", 32'(zero), 0);
    check("rst_ovf", 32'(ovf), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, 0, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), W + 1);
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vt[i].y));
      check($sformatf("vec%0d_z", i), 32'(z), 32'(vt[i].z));
      check($sformatf("vec%0d_excl", i), 32'(busy & done), 0);
    end

    // done lasts one cycle when not followed by a new start
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("held_y", 32'(y), 32'(vt[6].y));

    // back-to-back: XOR, then ADD accepted in the DONE cycle
    do_op(2'b11, 8'h0F, 8'h01, 1'b0, 0, lat);
    check("b2b_xor_y", 32'(y), 32'h0E);
    check("b2b_xor_z", 32'(z), 1);
    op = 2'b00; a = 8'h10; b = 8'h20; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_low", 32'(done), 0);
    check("b2b_busy_high", 32'(busy), 1);
    lat = 1;
    while (!done && lat < W + 6) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("b2b_lat", 32'(lat), W + 1);
    check("b2b_add_y", 32'(y), 32'h31);
    check("b2b_add_z", 32'(z), 0);

    // start pulse mid-RUN must be ignored
    do_op(2'b00, 8'h12, 8'h34, 1'b0, 3, lat);
    check("poke_lat", 32'(lat), W + 1);
    check("poke_y", 32'(y), 32'h46);
    check("poke_z", 32'(z), 0);

    // reset on the 4th RUN cycle
    @(negedge clk);
    op = 2'b10; a = 8'h0F; b = 8'h00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_y", 32'(y), 0);
    check("mid_rst_z", 32'(z), 0);
    do_op(2'b00, 8'hC8, 8'h64, 1'b0, 0, lat);
    check("post_rst_lat", 32'(lat), W + 1);
    check("post_rst_y", 32'(y), 32'h2C);
    check("post_rst_z", 32'(z), 1);

`ifdef SERIAL_ALU_FLAGS_EN
    do_op(2'b00, 8'h7F, 8'h01, 1'b0, 0, lat);
    check("flg1_y", 32'(y), 32'h80);
    check("flg1_ovf", 32'(ovf), 1);
    check("flg1_zero", 32'(zero), 0);
    do_op(2'b00, 8'hFF, 8'h01, 1'b0, 0, lat);
    check("flg2_y", 32'(y), 32'h00);
    check("flg2_zero", 32'(zero), 1);
    check("flg2_ovf", 32'(ovf), 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ro = 2'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model(ro, ra, rb, rc, ey, ez, eovf);
      do_op(ro, ra, rb, rc, 0, lat);
      check($sformatf("rnd%0d_lat", i), 32'(lat), W + 1);
      check($sformatf("rnd%0d_y", i), 32'(y), 32'(ey));
      check($sformatf("rnd%0d_z", i), 32'(z), 32'(ez));
`ifdef SERIAL_ALU_FLAGS_EN
      check($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(eovf));
      check($sformatf("rnd%0d_zero", i), 32'(zero), 32'(ey == '0));
`endif
    end

    check("busy_during_run", 32'(busy_gaps), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
